ili9341_init_sequencer: RTL and testbench
=========================================

// Module: ili9341_init_sequencer
// PURPOSE
// Table-driven power-up sequencer for the ILI9341 SPI panel. Walks the init script
// (hardware reset, command/data bytes, millisecond delays) and hands bytes one at a
// time to the SPI byte shifter over a valid/ready handshake. Drives panel RESET, CS
// and D/C. Sits between the top-level start strobe and the SPI transmitter.
// PARAMETERS
// DW           8        byte width sent to the shifter
// AW           6        script address width (max 64 entries)
// MS_CYC       100000   clk cycles per 1 ms delay unit
// RST_HI_CYC   1000     cycles RESET held high before the reset pulse
// RST_LO_CYC   1000     cycles RESET held low (>= 10 us at panel)
// RST_WAIT_MS  120      ms wait after RESET release before the first command
// PORTS
// clk        in   1    system clock
// rst        in   1    synchronous active-high reset
// start      in   1    one-cycle pulse; begins the sequence when not busy
// busy       out  1    high from accepted start until done
// done       out  1    high after END entry; held until next start or rst
// lcd_rst_n  out  1    panel RESET pin, active low
// lcd_cs_n   out  1    panel chip select, active low
// lcd_dc     out  1    0 = command byte, 1 = data byte
// tx_valid   out  1    byte available to the shifter
// tx_ready   in   1    shifter accepts tx_data on tx_valid & tx_ready
// tx_data    out  DW   byte to shift
// tx_idle    in   1    shifter has finished the last SCLK edge of the last byte
// BEHAVIOUR
// - Reset: busy=0, done=0, lcd_rst_n=1, lcd_cs_n=1, lcd_dc=1, tx_valid=0, tx_data=0,
//   state=IDLE, ptr=0, counters=0. rst mid-sequence aborts at the next edge; no drain.
// - Script entry = {op[1:0], arg[DW-1:0]}. op: CMD=0 (dc=0), DATA=1 (dc=1),
//   DELAY=2 (arg ms; 0 = no wait), END=3. ROM read is registered: 1 cycle latency.
// - FSM: IDLE -start-> RST_HI (RST_HI_CYC) -> RST_LO (lcd_rst_n=0, RST_LO_CYC) ->
//   RST_WAIT (RST_WAIT_MS*MS_CYC) -> FETCH -> DECODE -> {SEND | DRAIN | DELAY | FIN}.
// - FETCH presents ptr to ROM. DECODE registers the entry. CMD/DATA: go to SEND.
//   DELAY/END: go to DRAIN.
// - SEND: lcd_cs_n=0, lcd_dc per op, tx_valid=1, tx_data=arg, all held stable
//   until tx_ready. On the handshake cycle: tx_valid->0, ptr+1, go to FETCH.
//   CS stays low across consecutive CMD/DATA entries. dc changes only while
//   tx_valid=0.
// - DRAIN: wait for tx_idle=1, then lcd_cs_n=1. Next state is DELAY (arg*MS_CYC
//   cycles, ms counter plus sub-ms counter) or FIN. When DRAIN is entered with
//   cs already high, it exits on the first cycle.
// - DELAY with arg=0 goes straight to FETCH next cycle. After DELAY: ptr+1, FETCH.
// - FIN: done=1, busy=0, lcd_cs_n=1, state IDLE. start in IDLE with done=1
//   clears done and restarts at RST_HI with ptr=0.
// - start while busy is ignored. tx_ready while tx_valid=0 is ignored.
// - Pointer saturation: if ptr reaches 2**AW-1 and that entry is not END, the entry
//   executes and the sequencer then goes through DRAIN to FIN. Never wraps to 0.
// - Latency: start pulse at edge N gives busy=1 at N+1; lcd_rst_n falls at
//   N+1+RST_HI_CYC.
// STRUCTURE
// - Package ili9341_pkg: op_t enum {OP_CMD, OP_DATA, OP_DELAY, OP_END},
//   seq_state_t enum, entry struct {op_t op; logic [DW-1:0] arg}, ILI9341 command
//   constants (SWRESET=8'h01, SLPOUT=8'h11, PIXFMT=8'h3A, MADCTL=8'h36,
//   DISPON=8'h29).
// - One sub-module, ili9341_init_rom: registered-output script ROM (addr in,
//   entry out). The sequencer holds only FSM, ptr and counters.
// TESTING (MS_CYC=4, RST_HI_CYC=2, RST_LO_CYC=3, RST_WAIT_MS=1, test ROM)
// - Reset/idle: hold rst 3 cycles -> all outputs at reset values; no tx_valid
//   for 50 cycles without start.
// - Reset pulse: start -> lcd_rst_n low exactly 3 cycles, first tx_valid no
//   earlier than 4 cycles after release.
// - Script {CMD 3A, DATA 55, DELAY 2, CMD 29, END}, tx_ready always 1 -> bytes
//   3A(dc0), 55(dc1) with cs low throughout; cs high during >= 8-cycle gap;
//   29(dc0); done=1.
// - Backpressure: tx_ready low 10 cycles on byte 55 -> tx_valid/tx_data/dc stable;
//   cs stays low until tx_idle=1.
// - start during busy ignored; rst mid-SEND -> next edge cs_n=1, tx_valid=0,
//   busy=0; later start replays from entry 0.
// - DELAY 0 and a 64-entry ROM with no END -> no stall, done=1 after entry 63,
//   ptr never wraps.

Source files
------------

// File: rtl/ili9341_pkg.sv
// Shared types and panel command codes for the ILI9341 init sequencer and its script ROM.
`timescale 1ns/1ps
package ili9341_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HI,
    S_RST_LO,
    S_RST_WAIT,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_DRAIN,
    S_DELAY,
    S_FIN
  } seq_state_t;

  typedef struct packed {
    op_t               op;
    logic [BYTE_W-1:0] arg;
  } entry_t;

  localparam logic [BYTE_W-1:0] SWRESET = 8'h01;
  localparam logic [BYTE_W-1:0] SLPOUT  = 8'h11;
  localparam logic [BYTE_W-1:0] PIXFMT  = 8'h3A;
  localparam logic [BYTE_W-1:0] MADCTL  = 8'h36;
  localparam logic [BYTE_W-1:0] DISPON  = 8'h29;

  function automatic entry_t mk_entry(input op_t op, input logic [BYTE_W-1:0] arg);
    entry_t e;
    e.op  = op;
    e.arg = arg;
    return e;
  endfunction

endpackage

// File: rtl/ili9341_init_rom.sv
// Init script ROM with registered read. SCRIPT 0 is the panel bring-up script;
// 1 and 2 are short bring-up test scripts (2 fills every address and has no END).
`timescale 1ns/1ps
module ili9341_init_rom
  import ili9341_pkg::*;
#(
  parameter int AW     = 6,
  parameter int SCRIPT = 0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output entry_t        entry_o
);

  function automatic entry_t script_entry(input int idx);
    entry_t e;
    e = mk_entry(OP_END, '0);
    if (SCRIPT == 1) begin
      case (idx)
        0:       e = mk_entry(OP_CMD, PIXFMT);
        1:       e = mk_entry(OP_DATA, 8'h55);
        2:       e = mk_entry(OP_DELAY, 8'd2);
        3:       e = mk_entry(OP_CMD, DISPON);
        default: e = mk_entry(OP_END, '0);
      endcase
    end else if (SCRIPT == 2) begin
      case (idx % 4)
        0:       e = mk_entry(OP_CMD, BYTE_W'(idx));
        2:       e = mk_entry(OP_DELAY, 8'd0);
        default: e = mk_entry(OP_DATA, BYTE_W'(idx));
      endcase
    end else begin
      case (idx)
        0:       e = mk_entry(OP_CMD, SWRESET);
        1:       e = mk_entry(OP_DELAY, 8'd5);
        2:       e = mk_entry(OP_CMD, SLPOUT);
        3:       e = mk_entry(OP_DELAY, 8'd120);
        4:       e = mk_entry(OP_CMD, PIXFMT);
        5:       e = mk_entry(OP_DATA, 8'h55);
        6:       e = mk_entry(OP_CMD, MADCTL);
        7:       e = mk_entry(OP_DATA, 8'h48);
        8:       e = mk_entry(OP_CMD, DISPON);
        9:       e = mk_entry(OP_DELAY, 8'd20);
        default: e = mk_entry(OP_END, '0);
      endcase
    end
    return e;
  endfunction

  entry_t rom [2**AW];

  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_rom
    assign rom[gi] = script_entry(gi);
  end

  always_ff @(posedge clk) begin
    entry_o <= rom[addr_i];
  end

endmodule

// File: rtl/ili9341_init_sequencer.sv
// Table-driven ILI9341 power-up sequencer: hardware reset pulse, then walks the
// script ROM handing bytes to the SPI shifter and timing millisecond delays.
`timescale 1ns/1ps
module ili9341_init_sequencer
  import ili9341_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 6,
  parameter int MS_CYC      = 100000,
  parameter int RST_HI_CYC  = 1000,
  parameter int RST_LO_CYC  = 1000,
  parameter int RST_WAIT_MS = 120,
  parameter int SCRIPT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          lcd_rst_n,
  output logic          lcd_cs_n,
  output logic          lcd_dc,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [DW-1:0] tx_data,
  input  logic          tx_idle
);

  localparam logic [AW-1:0] PTR_MAX = '1;
  localparam logic [31:0]   HI_LAST = 32'(RST_HI_CYC - 1);
  localparam logic [31:0]   LO_LAST = 32'(RST_LO_CYC - 1);
  localparam logic [31:0]   MS_LAST = 32'(MS_CYC - 1);
  localparam logic [15:0]   WAIT_MS = 16'(RST_WAIT_MS);

  seq_state_t        state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [15:0]       ms_q, ms_d;
  op_t               op_q, op_d;
  logic [BYTE_W-1:0] arg_q, arg_d;
  logic [DW-1:0]     data_q, data_d;
  logic              dc_q, dc_d;
  logic              cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic              sat_q, sat_d;
  entry_t            rom_entry;
  logic [15:0]       ms_target;
  logic              wait_done;

  ili9341_init_rom #(
    .AW     (AW),
    .SCRIPT (SCRIPT)
  ) u_rom (
    .clk     (clk),
    .addr_i  (ptr_q),
    .entry_o (rom_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ms_q    <= '0;
      op_q    <= OP_CMD;
      arg_q   <= '0;
      data_q  <= '0;
      dc_q    <= 1'b1;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ms_q    <= ms_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  // One ms timer serves both the post-reset wait and script delays; a zero target ends at once.
  always_comb begin
    ms_target = (state_q == S_RST_WAIT) ? WAIT_MS : 16'(arg_q);
    wait_done = (ms_target == 16'd0) ||
                ((cnt_q == MS_LAST) && (ms_q == ms_target - 16'd1));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ms_d    = ms_q;
    op_d    = op_q;
    arg_d   = arg_q;
    data_d  = data_q;
    dc_d    = dc_q;
    cs_n_d  = cs_n_q;
    done_d  = done_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST_HI;
          ptr_d   = '0;
          cnt_d   = '0;
          ms_d    = '0;
          done_d  = 1'b0;
          sat_d   = 1'b0;
        end
      end
      S_RST_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d   = '0;
          state_d = S_RST_LO;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RST_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d   = '0;
          ms_d    = '0;
          state_d = S_RST_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RST_WAIT, S_DELAY: begin
        if (wait_done) begin
          cnt_d = '0;
          ms_d  = '0;
          if (state_q == S_RST_WAIT) begin
            state_d = S_FETCH;
          end else if (ptr_q == PTR_MAX) begin
            sat_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == MS_LAST) begin
          cnt_d = '0;
          ms_d  = ms_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d  = rom_entry.op;
        arg_d = rom_entry.arg;
        if (rom_entry.op == OP_CMD || rom_entry.op == OP_DATA) begin
          dc_d    = (rom_entry.op == OP_DATA);
          data_d  = DW'(rom_entry.arg);
          cs_n_d  = 1'b0;
          state_d = S_SEND;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (ptr_q == PTR_MAX) begin
            sat_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (cs_n_q || tx_idle) begin
          cs_n_d = 1'b1;
          if (!sat_q && op_q == OP_DELAY) begin
            cnt_d   = '0;
            ms_d    = '0;
            state_d = S_DELAY;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        cs_n_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = !(state_q == S_IDLE || state_q == S_FIN);
    done      = done_q || (state_q == S_FIN);
    lcd_rst_n = (state_q != S_RST_LO);
    lcd_cs_n  = cs_n_q;
    lcd_dc    = dc_q;
    tx_valid  = (state_q == S_SEND);
    tx_data   = data_q;
  end

endmodule

// File: tb/tb_ili9341_init_sequencer.sv
// Bench for the init sequencer: two instances (short script, full 64-entry script)
// checked against a byte-stream model derived from the scripts plus directed timing checks.
`timescale 1ns/1ps
module tb_ili9341_init_sequencer;

  logic       clk;
  logic [1:0] rst, start, busy, done, lcd_rst_n, lcd_cs_n, lcd_dc, tx_valid, tx_ready, tx_idle;
  logic [7:0] tx_data [2];
  logic [3:0] sh_cnt [2];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_data   [2][64];
  bit         exp_dc     [2][64];
  bit         exp_contig [2][64];
  int         exp_n      [2];
  int         idx        [2];
  int         hi_cnt     [2];
  int         gap        [2][64];
  bit         pv_valid   [2];
  bit         pv_ready   [2];
  bit         pv_dc      [2];
  bit         pv_cs      [2];
  bit         pv_idle    [2];
  logic [7:0] pv_data    [2];

  int s1_op  [5] = '{0, 1, 2, 0, 3};
  int s1_arg [5] = '{8'h3A, 8'h55, 2, 8'h29, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ili9341_init_sequencer #(
      .DW(8), .AW(6), .MS_CYC(4), .RST_HI_CYC(2), .RST_LO_CYC(3), .RST_WAIT_MS(1),
      .SCRIPT(gi + 1)
    ) u_dut (
      .clk(clk), .rst(rst[gi]), .start(start[gi]), .busy(busy[gi]), .done(done[gi]),
      .lcd_rst_n(lcd_rst_n[gi]), .lcd_cs_n(lcd_cs_n[gi]), .lcd_dc(lcd_dc[gi]),
      .tx_valid(tx_valid[gi]), .tx_ready(tx_ready[gi]), .tx_data(tx_data[gi]),
      .tx_idle(tx_idle[gi])
    );
  end

  assign tx_idle = {sh_cnt[1] == 4'd0, sh_cnt[0] == 4'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Script k (0: short test script, 1: 64-entry pattern), op/arg as plain ints.
  function automatic int script_op(input int k, input int i);
    if (k == 0) return (i < 5) ? s1_op[i] : 3;
    if (i % 4 == 2) return 2;
    return (i % 4 == 0) ? 0 : 1;
  endfunction

  function automatic int script_arg(input int k, input int i);
    if (k == 0) return (i < 5) ? s1_arg[i] : 0;
    return (i % 4 == 2) ? 0 : i;
  endfunction

  // Expected byte stream: every CMD/DATA entry up to END or the last address;
  // CS must stay low between bytes whose entries are adjacent in the script.
  task automatic build_model();
    for (int k = 0; k < 2; k++) begin
      bit prev_byte = 1'b0;
      exp_n[k] = 0;
      for (int i = 0; i < 64; i++) begin
        int op = script_op(k, i);
        if (op == 3) break;
        if (op <= 1) begin
          exp_data[k][exp_n[k]]   = 8'(script_arg(k, i));
          exp_dc[k][exp_n[k]]     = (op == 1);
          exp_contig[k][exp_n[k]] = prev_byte;
          exp_n[k]++;
          prev_byte = 1'b1;
        end else begin
          prev_byte = 1'b0;
        end
      end
    end
  endtask

  // Shifter model: busy for 8 cycles after each accepted byte.
  initial begin
    sh_cnt[0] = 4'd0;
    sh_cnt[1] = 4'd0;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) sh_cnt[k] <= 4'd0;
        else if (tx_valid[k] && tx_ready[k]) sh_cnt[k] <= 4'd8;
        else if (sh_cnt[k] != 4'd0) sh_cnt[k] <= sh_cnt[k] - 4'd1;
      end
    end
  end

  // Per-cycle compare against the byte-stream model and handshake rules.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          pv_valid[k] = 1'b0;
          pv_cs[k]    = 1'b1;
          hi_cnt[k]   = 0;
        end else begin
          if (pv_valid[k] && !pv_ready[k]) begin
            check("hold_valid", tx_valid[k], 1);
            check("hold_data", tx_data[k], pv_data[k]);
            check("hold_dc", lcd_dc[k], pv_dc[k]);
          end
          if (tx_valid[k]) begin
            check("valid_cs_low", lcd_cs_n[k], 0);
            check("valid_busy", busy[k], 1);
          end
          if (tx_valid[k] && tx_ready[k]) begin
            if (idx[k] < exp_n[k]) begin
              check("byte_data", tx_data[k], exp_data[k][idx[k]]);
              check("byte_dc", lcd_dc[k], exp_dc[k][idx[k]]);
              if (exp_contig[k][idx[k]]) check("cs_low_between_bytes", hi_cnt[k], 0);
              gap[k][idx[k]] = hi_cnt[k];
              $display("dut%0d byte %0d: data=%02h dc=%0d", k, idx[k], tx_data[k], lcd_dc[k]);
            end else begin
              check("extra_byte", idx[k], exp_n[k] - 1);
            end
            idx[k]++;
            hi_cnt[k] = 0;
          end
          if (!pv_cs[k] && lcd_cs_n[k]) check("cs_rise_after_idle", pv_idle[k], 1);
          if (lcd_cs_n[k]) hi_cnt[k]++;
          if (done[k]) check("done_not_busy", busy[k], 0);
          pv_valid[k] = tx_valid[k];
          pv_ready[k] = tx_ready[k];
          pv_data[k]  = tx_data[k];
          pv_dc[k]    = lcd_dc[k];
          pv_cs[k]    = lcd_cs_n[k];
          pv_idle[k]  = tx_idle[k];
        end
      end
    end
  end

  task automatic pulse_start(input int k);
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int limit, input string name);
    int n = 0;
    while (!done[k] && n < limit) begin @(negedge clk); n++; end
    check(name, done[k], 1);
  endtask

  task automatic wait_valid(input int k, input logic [7:0] d, input bit any, input string name);
    int n = 0;
    while (!(tx_valid[k] && (any || tx_data[k] == d)) && n < 1000) begin @(negedge clk); n++; end
    check(name, tx_valid[k], 1);
  endtask

  initial begin
    int n, lo, w;
    bit saw;
    rst = 2'b11; start = 2'b00; tx_ready = 2'b11;
    idx[0] = 0; idx[1] = 0;
    build_model();
    check("model_len0", exp_n[0], 3);
    check("model_first0", {exp_dc[0][0], exp_data[0][0]}, 9'h03A);
    check("model_len1", exp_n[1], 48);
    check("model_last1", {exp_dc[1][47], exp_data[1][47]}, 9'h13F);

    // Reset values and idle behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_lcd_rst_n", lcd_rst_n[0], 1);
    check("rst_cs_n", lcd_cs_n[0], 1);
    check("rst_dc", lcd_dc[0], 1);
    check("rst_tx_valid", tx_valid[0], 0);
    check("rst_tx_data", tx_data[0], 0);
    @(posedge clk); #1 rst[0] = 1'b0;
    saw = 1'b0;
    repeat (50) begin @(negedge clk); saw |= tx_valid[0] | busy[0]; end
    check("idle_no_activity", saw, 0);

    // Reset pulse timing and the basic script with tx_ready always high
    idx[0] = 0;
    pulse_start(0);
    @(negedge clk);
    check("busy_after_start", busy[0], 1);
    n = 0;
    do begin @(negedge clk); n++; end while (lcd_rst_n[0] && n < 100);
    check("rst_fall_latency", n, 2);
    lo = 0;
    while (!lcd_rst_n[0] && lo < 100) begin lo++; @(negedge clk); end
    check("rst_low_cycles", lo, 3);
    w = 0;
    while (!tx_valid[0] && w < 100) begin @(negedge clk); w++; end
    check("first_valid_ge4", w >= 4, 1);
    check("first_valid_delay", w, 6);
    wait_done(0, 500, "basic_done");
    check("basic_busy_low", busy[0], 0);
    check("basic_cs_high", lcd_cs_n[0], 1);
    check("basic_byte_count", idx[0], 3);
    check("delay_gap_ge8", gap[0][2] >= 8, 1);

    // Backpressure on byte 55, with a start pulse during the stall that must be ignored
    idx[0] = 0;
    pulse_start(0);
    check("restart_clears_done", done[0], 0);
    wait_valid(0, 8'h3A, 1'b0, "bp_first_byte");
    @(posedge clk); #1 tx_ready[0] = 1'b0;
    wait_valid(0, 8'h55, 1'b0, "bp_second_byte");
    repeat (3) @(negedge clk);
    pulse_start(0);
    repeat (5) @(negedge clk);
    check("bp_busy_held", busy[0], 1);
    check("bp_valid_held", tx_valid[0], 1);
    check("bp_data_held", tx_data[0], 8'h55);
    check("bp_dc_held", lcd_dc[0], 1);
    @(posedge clk); #1 tx_ready[0] = 1'b1;
    wait_done(0, 500, "bp_done");
    check("bp_byte_count", idx[0], 3);

    // Reset in the middle of SEND, then a clean replay from entry 0
    tx_ready[0] = 1'b0;
    idx[0] = 0;
    pulse_start(0);
    wait_valid(0, 8'h00, 1'b1, "abort_send_reached");
    @(posedge clk); #1 rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_n", lcd_cs_n[0], 1);
    check("abort_tx_valid", tx_valid[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_lcd_rst_n", lcd_rst_n[0], 1);
    @(posedge clk); #1 rst[0] = 1'b0; tx_ready[0] = 1'b1;
    idx[0] = 0;
    pulse_start(0);
    wait_done(0, 500, "replay_done");
    check("replay_byte_count", idx[0], 3);

    // Full 64-entry script with DELAY 0 entries and no END
    @(posedge clk); #1 rst[1] = 1'b0;
    repeat (2) @(negedge clk);
    idx[1] = 0;
    pulse_start(1);
    wait_done(1, 5000, "full_done");
    check("full_byte_count", idx[1], 48);
    repeat (30) @(negedge clk);
    check("full_done_held", done[1], 1);
    check("full_no_wrap_busy", busy[1], 0);
    check("full_no_wrap_bytes", idx[1], 48);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
